// File: rtl/ysyx_25030077_exec_sequencer_if.sv
// Handshake and control bundle between the exec sequencer (master) and the
// fetch unit, load/store unit and datapath (slave).
interface ysyx_25030077_exec_sequencer_if;
   logic        io_ifu_req;
   logic        io_ifu_valid;
   logic        io_inst_latch;
   logic [2:0]  io_inst_class;
   logic        io_lsu_req;
   logic        io_lsu_wen;
   logic        io_lsu_valid;
   logic [2:0]  io_data_control;
   logic        io_rf_wen;
   logic        io_pc_wen;
   logic        io_busy;
   logic        io_halt;
   logic        io_err;
   logic [31:0] io_retired;

   modport master (
      output io_ifu_req, io_inst_latch, io_lsu_req, io_lsu_wen, io_data_control,
             io_rf_wen, io_pc_wen, io_busy, io_halt, io_err, io_retired,
      input  io_ifu_valid, io_inst_class, io_lsu_valid
   );

   modport slave (
      input  io_ifu_req, io_inst_latch, io_lsu_req, io_lsu_wen, io_data_control,
             io_rf_wen, io_pc_wen, io_busy, io_halt, io_err, io_retired,
      output io_ifu_valid, io_inst_class, io_lsu_valid
   );
endinterface

// File: rtl/ysyx_25030077_exec_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the ysyx_25030077 core.
// Optional IFU/LSU wait timeout is built when YSYX_25030077_SEQ_TIMEOUT_EN is defined.
module ysyx_25030077_exec_sequencer #(
   parameter int unsigned TIMEOUT = 255
) (
   input logic clock,
   input logic reset,
   ysyx_25030077_exec_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_ALU_IMM, C_ALU_REG, C_LOAD, C_STORE, C_PC_REL, C_BRANCH, C_EBREAK, C_ILLEGAL
   } cls_t;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("TIMEOUT must fit the 8-bit wait counter (1..255)");
   end

   state_t      state, state_n;
   cls_t        cls, cls_n;
   logic        armed;
   logic        timeout_hit;
   logic        ifu_req, lsu_req, lsu_wen, rf_wen, pc_wen, busy, halt, err;
   logic [2:0]  data_control;
   logic [31:0] retired;

   // Operand select while the instruction executes: rs1/rs2 compare or add -> 3, pc+imm -> 1.
   function automatic logic [2:0] exec_code(cls_t c);
      case (c)
         C_ALU_REG, C_BRANCH: exec_code = 3'd3;
         C_PC_REL:            exec_code = 3'd1;
         default:             exec_code = 3'd0;
      endcase
   endfunction

`ifdef YSYX_25030077_SEQ_TIMEOUT_EN
   logic [7:0] wait_cnt;

   // A valid arriving on the last allowed cycle is checked first in the FSM and wins.
   assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         wait_cnt <= '0;
      else if (state_n != state)
         wait_cnt <= '0;
      else if (state == S_FETCH || state == S_MEM)
         wait_cnt <= wait_cnt + 8'd1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_n = state;
      cls_n   = cls;
      unique case (state)
         S_IDLE:   if (armed) state_n = S_FETCH;
         S_FETCH:  if (bus.io_ifu_valid) state_n = S_DECODE;
                   else if (timeout_hit) state_n = S_HALT;
         S_DECODE: begin
            cls_n   = cls_t'(bus.io_inst_class);
            state_n = (cls_n == C_EBREAK || cls_n == C_ILLEGAL) ? S_HALT : S_EXEC;
         end
         S_EXEC:   state_n = (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
         S_MEM:    if (bus.io_lsu_valid) state_n = S_WB;
                   else if (timeout_hit) state_n = S_HALT;
         S_WB:     state_n = S_FETCH;
         S_HALT:   state_n = S_HALT;
         default:  state_n = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state, so each one is a clean Moore
   // function of the state being entered and the async reset clears it at once.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         cls          <= C_ALU_IMM;
         armed        <= 1'b0;
         ifu_req      <= 1'b0;
         lsu_req      <= 1'b0;
         lsu_wen      <= 1'b0;
         data_control <= 3'd0;
         rf_wen       <= 1'b0;
         pc_wen       <= 1'b0;
         busy         <= 1'b0;
         halt         <= 1'b0;
         err          <= 1'b0;
         retired      <= '0;
      end else begin
         state   <= state_n;
         cls     <= cls_n;
         if (state == S_IDLE) armed <= 1'b1;

         ifu_req <= (state_n == S_FETCH);
         lsu_req <= (state_n == S_MEM);
         lsu_wen <= (state_n == S_MEM) && (cls_n == C_STORE);
         pc_wen  <= (state_n == S_WB);
         rf_wen  <= (state_n == S_WB) &&
                    (cls_n == C_ALU_IMM || cls_n == C_ALU_REG ||
                     cls_n == C_LOAD    || cls_n == C_PC_REL);
         busy    <= (state_n != S_IDLE) && (state_n != S_HALT);
         halt    <= (state_n == S_HALT);

         case (state_n)
            S_EXEC:  data_control <= exec_code(cls_n);
            S_WB:    data_control <= (cls_n == C_LOAD) ? 3'd2 : exec_code(cls_n);
            default: data_control <= 3'd0;
         endcase

         // Every route into HALT except a decoded EBREAK is an error.
         if (state_n == S_HALT && state != S_HALT &&
             !(state == S_DECODE && cls_n == C_EBREAK))
            err <= 1'b1;

         if (state == S_WB) retired <= retired + 32'd1;
      end
   end

   assign bus.io_inst_latch   = (state == S_FETCH) && bus.io_ifu_valid;
   assign bus.io_ifu_req      = ifu_req;
   assign bus.io_lsu_req      = lsu_req;
   assign bus.io_lsu_wen      = lsu_wen;
   assign bus.io_data_control = data_control;
   assign bus.io_rf_wen       = rf_wen;
   assign bus.io_pc_wen       = pc_wen;
   assign bus.io_busy         = busy;
   assign bus.io_halt         = halt;
   assign bus.io_err          = err;
   assign bus.io_retired      = retired;

endmodule

// File: tb/tb_ysyx_25030077_exec_sequencer.sv
// Scoreboard bench for the exec sequencer: a driver issues random instructions
// and queues expectations; a monitor follows each instruction through the pipeline.
module tb_ysyx_25030077_exec_sequencer;

   localparam int TO = 8;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   ysyx_25030077_exec_sequencer_if bus ();

   ysyx_25030077_exec_sequencer #(.TIMEOUT(TO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          cls;
      int          fdelay;
      int          mdelay;
      int unsigned ret;
   } item_t;

   item_t       exp_q[$];
   item_t       cur;
   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned exp_retired = 0;
   int          mphase = 0;
   int          fcnt = 0;
   int          mcnt = 0;
   bit          chk_ret = 1'b0;
   bit          mon_off = 1'b0;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference rules: which operand pair each class feeds the ALU.
   function automatic int exp_exec_dc(int c);
      case (c)
         1, 5:    return 3;   // rs1 op rs2 (register ALU, branch compare)
         4:       return 1;   // pc + imm
         default: return 0;   // rs1 + imm
      endcase
   endfunction

   function automatic int exp_wb_dc(int c);
      return (c == 2) ? 2 : exp_exec_dc(c);
   endfunction

   function automatic bit writes_rd(int c);
      return (c == 0 || c == 1 || c == 2 || c == 4);
   endfunction

   function automatic bit is_mem(int c);
      return (c == 2 || c == 3);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_ifu_req"}, bus.io_ifu_req, 0);
      check({tag, "_inst_latch"}, bus.io_inst_latch, 0);
      check({tag, "_lsu_req"}, bus.io_lsu_req, 0);
      check({tag, "_lsu_wen"}, bus.io_lsu_wen, 0);
      check({tag, "_data_control"}, bus.io_data_control, 0);
      check({tag, "_rf_wen"}, bus.io_rf_wen, 0);
      check({tag, "_pc_wen"}, bus.io_pc_wen, 0);
      check({tag, "_busy"}, bus.io_busy, 0);
      check({tag, "_halt"}, bus.io_halt, 0);
      check({tag, "_err"}, bus.io_err, 0);
      check({tag, "_retired"}, bus.io_retired, 0);
   endtask

   // Ends at the negedge of the first FETCH cycle.
   task automatic do_reset();
      reset = 1'b0;
      #1;
      check_all_zero("reset");
      exp_retired = 0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("boot_idle_req", bus.io_ifu_req, 0);
      @(negedge clock);
      check("boot_fetch_req", bus.io_ifu_req, 1);
   endtask

   // Issue one instruction: fetch answered after fd waits, memory after md waits.
   task automatic run_instr(input int c, input int fd, input int md);
      int guard = 0;
      while (!bus.io_ifu_req) begin
         @(negedge clock);
         guard++;
         if (guard > 50) begin
            check("fetch_req_wait", 0, 1);
            return;
         end
      end
      if (c < 6) exp_retired++;
      exp_q.push_back('{cls: c, fdelay: fd, mdelay: md, ret: exp_retired});
      for (int k = 0; k <= fd; k++) begin
         bus.io_ifu_valid  = (k == fd);
         bus.io_inst_class = (k == fd) ? 3'(c) : 3'($urandom_range(7));
         @(negedge clock);
      end
      // DECODE: stray valids here must be ignored.
      bus.io_ifu_valid = (c < 6) ? 1'($urandom_range(1)) : 1'b0;
      bus.io_lsu_valid = (c < 6) ? 1'($urandom_range(1)) : 1'b0;
      if (c >= 6) return;
      @(negedge clock);
      bus.io_ifu_valid = 1'b0;
      bus.io_lsu_valid = 1'($urandom_range(1));
      @(negedge clock);
      if (is_mem(c)) begin
         for (int k = 0; k <= md; k++) begin
            bus.io_lsu_valid = (k == md);
            @(negedge clock);
         end
      end
      bus.io_lsu_valid = 1'b0;
      @(negedge clock);
   endtask

   task automatic wait_drain(input string tag);
      int guard = 0;
      while (!(exp_q.size() == 0 && mphase == 0 && !chk_ret)) begin
         @(negedge clock);
         guard++;
         if (guard > 2000) begin
            check({tag, "_drain_wait"}, 0, 1);
            return;
         end
      end
   endtask

   task automatic wait_halted(input string tag);
      int guard = 0;
      while (mphase != 6) begin
         @(negedge clock);
         guard++;
         if (guard > 100) begin
            check({tag, "_halt_wait"}, 0, 1);
            return;
         end
      end
   endtask

   // Drive a LOAD/STORE from FETCH into its first MEM cycle, unscored.
   task automatic start_mem(input int c);
      bus.io_ifu_valid  = 1'b1;
      bus.io_inst_class = 3'(c);
      @(negedge clock);
      bus.io_ifu_valid = 1'b0;
      bus.io_lsu_valid = 1'b0;
      repeat (2) @(negedge clock);
      check("mem_entry_req", bus.io_lsu_req, 1);
   endtask

   // Monitor: one sample per cycle, away from the rising edge.
   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (!reset) begin
            exp_q.delete();
            mphase  = 0;
            fcnt    = 0;
            mcnt    = 0;
            chk_ret = 1'b0;
            continue;
         end
         if (mon_off) continue;
         if (chk_ret) begin
            check("retired", bus.io_retired, cur.ret);
            chk_ret = 1'b0;
         end
         case (mphase)
            0: begin
               if (exp_q.size() == 0) fcnt = 0;
               else if (bus.io_ifu_req) fcnt++;
               if (bus.io_inst_latch) begin
                  if (exp_q.size() == 0) begin
                     check("unexpected_latch", 1, 0);
                  end else begin
                     cur = exp_q.pop_front();
                     check("fetch_req_cycles", fcnt, cur.fdelay + 1);
                     check("dc_fetch", bus.io_data_control, 0);
                     fcnt   = 0;
                     mphase = 1;
                  end
               end
            end
            1: begin
               check("dc_decode", bus.io_data_control, 0);
               check("busy_decode", bus.io_busy, 1);
               mphase = (cur.cls >= 6) ? 5 : 2;
            end
            2: begin
               check("dc_exec", bus.io_data_control, exp_exec_dc(cur.cls));
               check("rf_wen_exec", bus.io_rf_wen, 0);
               mcnt   = 0;
               mphase = 3;
            end
            3: begin
               if (bus.io_lsu_req) begin
                  mcnt++;
                  check("lsu_wen", bus.io_lsu_wen, is_mem(cur.cls) && cur.cls == 3);
                  check("dc_mem", bus.io_data_control, 0);
               end else if (bus.io_pc_wen) begin
                  check("dc_wb", bus.io_data_control, exp_wb_dc(cur.cls));
                  check("rf_wen_wb", bus.io_rf_wen, writes_rd(cur.cls));
                  check("mem_req_cycles", mcnt, is_mem(cur.cls) ? cur.mdelay + 1 : 0);
                  chk_ret = 1'b1;
                  mphase  = 0;
               end
            end
            5: begin
               check("halt_flag", bus.io_halt, 1);
               check("halt_err", bus.io_err, cur.cls == 7);
               check("halt_busy", bus.io_busy, 0);
               check("halt_ifu_req", bus.io_ifu_req, 0);
               check("halt_pc_wen", bus.io_pc_wen, 0);
               mphase = 6;
            end
            default: ;
         endcase
      end
   end

   task automatic check_halted(input bit e);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         bus.io_ifu_valid = 1'b1;
         bus.io_lsu_valid = 1'b1;
         #1;
         check("halted_latch", bus.io_inst_latch, 0);
         @(negedge clock);
         bus.io_ifu_valid = 1'b0;
         bus.io_lsu_valid = 1'b0;
         check("halted_halt", bus.io_halt, 1);
         check("halted_err", bus.io_err, e);
         check("halted_busy", bus.io_busy, 0);
         check("halted_reqs", {bus.io_ifu_req, bus.io_lsu_req, bus.io_rf_wen, bus.io_pc_wen}, 0);
         check("halted_dc", bus.io_data_control, 0);
         check("halted_retired", bus.io_retired, exp_retired);
      end
   endtask

   initial begin
      bit held;
      bus.io_ifu_valid  = 1'b0;
      bus.io_inst_class = 3'd0;
      bus.io_lsu_valid  = 1'b0;

      // Back-to-back ALU-imm stream from reset.
      do_reset();
      fork
         repeat (10) run_instr(0, 0, 0);
         begin
            repeat (4) @(negedge clock);
            check("retired_after_4", bus.io_retired, 1);
            repeat (36) @(negedge clock);
            check("retired_after_40", bus.io_retired, 10);
         end
      join

      // Directed class coverage, then a random stream.
      run_instr(2, 0, 3);
      run_instr(3, 1, 0);
      run_instr(4, 0, 0);
      run_instr(5, 2, 0);
      run_instr(1, 0, 0);
      for (int i = 0; i < 150; i++)
         run_instr($urandom_range(5), $urandom_range(3), $urandom_range(4));
      wait_drain("random");

      // EBREAK halts cleanly and ignores further traffic.
      run_instr(6, 0, 0);
      wait_halted("ebreak");
      check_halted(1'b0);

      // Illegal instruction halts with error.
      do_reset();
      run_instr(0, 0, 0);
      run_instr(7, 1, 0);
      wait_halted("illegal");
      check_halted(1'b1);

      // Reset in the middle of a memory wait drops the request at once.
      do_reset();
      run_instr(0, 0, 0);
      wait_drain("pre_mem_reset");
      check("retired_before_reset", bus.io_retired, 1);
      mon_off = 1'b1;
      start_mem(2);
      #2 reset = 1'b0;
      #1;
      check("reset_mid_mem_lsu_req", bus.io_lsu_req, 0);
      check("reset_mid_mem_retired", bus.io_retired, 0);
      do_reset();

      // Memory response that never arrives.
      start_mem(3);
`ifdef YSYX_25030077_SEQ_TIMEOUT_EN
      repeat (TO - 1) @(negedge clock);
      check("timeout_last_wait_req", bus.io_lsu_req, 1);
      check("timeout_last_wait_halt", bus.io_halt, 0);
      @(negedge clock);
      check("timeout_halt", bus.io_halt, 1);
      check("timeout_err", bus.io_err, 1);
      check("timeout_lsu_req", bus.io_lsu_req, 0);
`else
      held = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clock);
         if (!bus.io_lsu_req || !bus.io_lsu_wen || bus.io_err || bus.io_halt) held = 1'b0;
      end
      check("mem_wait_unbounded", held, 1);
      check("mem_wait_no_err", bus.io_err, 0);
`endif
      reset = 1'b0;
      #1;
      check_all_zero("final_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_25030077_exec_sequencer.md
# ysyx_25030077_exec_sequencer

Multi-cycle control FSM for the single-issue ysyx_25030077 core. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. It drives the 3-bit operand-select code that steers the operand mux (rs1/pc/mem-data onto operand 1, rs2/imm/zero onto operand 2), and handshakes with the instruction-fetch and load/store units. It also gates register-file and PC writes and keeps a retired-instruction count.

## Interface
Parameters:
- TIMEOUT, 255, wait-cycle limit for IFU/LSU responses (8-bit counter; used only with timeout feature)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- io_ifu_req  out  1  fetch request, held until accepted
- io_ifu_valid  in  1  instruction available this cycle
- io_inst_latch  out  1  one-cycle pulse: capture instruction into IR
- io_inst_class  in  3  decoded class: 0 ALU-imm, 1 ALU-reg, 2 LOAD, 3 STORE, 4 PC-rel (AUIPC/JAL/JALR), 5 BRANCH, 6 EBREAK, 7 illegal
- io_lsu_req  out  1  memory request, held until accepted
- io_lsu_wen  out  1  1 = store, 0 = load; valid while io_lsu_req
- io_lsu_valid  in  1  memory access complete this cycle
- io_data_control  out  3  operand-select code to operand mux
- io_rf_wen  out  1  register-file write enable
- io_pc_wen  out  1  PC update enable
- io_busy  out  1  FSM not in IDLE/HALT
- io_halt  out  1  sticky halt
- io_err  out  1  sticky error (illegal instruction or timeout)
- io_retired  out  32  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: lasts one cycle after reset deassertion, then goes to FETCH.
- FETCH: io_ifu_req=1. When io_ifu_valid=1 in the same cycle, io_inst_latch=1 and the FSM goes to DECODE.
- DECODE: io_inst_class is registered into cls.
  - cls 6 goes to HALT (halt=1).
  - cls 7 goes to HALT (halt=1, err=1).
  - Any other class goes to EXEC.
- EXEC: io_data_control is driven from cls.
  - 0 gives 0; 1 gives 3; 2 gives 0; 3 gives 0; 4 gives 1; 5 gives 3.
  - LOAD and STORE go to MEM; all other classes go to WB.
- MEM: io_lsu_req=1, io_lsu_wen=(cls==3), io_data_control=0. On io_lsu_valid, go to WB.
- WB:
  - io_data_control = 2 for LOAD, otherwise the same value as in EXEC.
  - io_rf_wen = 1 for classes 0, 1, 2, 4.
  - io_pc_wen = 1 always.
  - io_retired increments (wraps 0xFFFFFFFF to 0).
  - Next state is FETCH.
- HALT: absorbing state until reset. Every request and enable output is 0, and io_data_control is 0.
- io_data_control is 0 in IDLE, FETCH and DECODE.
- io_busy = 1 in FETCH, DECODE, EXEC, MEM and WB.

## Timing
- Reset (asynchronous, reset=0): state goes to IDLE. Every output is 0, including io_retired, io_halt and io_err.
  - Reset mid-FETCH or mid-MEM drops the request immediately, without waiting for a clock edge.
- All outputs are Moore (decoded from state and cls), except io_inst_latch, which is FETCH && io_ifu_valid.
- Minimum latency with zero-wait responses:
  - Non-memory class: 4 cycles per instruction (FETCH, DECODE, EXEC, WB).
  - LOAD/STORE: 5 cycles.
- Requests stay asserted and stable until the matching valid arrives.
- io_ifu_valid is ignored outside FETCH; io_lsu_valid is ignored outside MEM.
- The first FETCH cycle occurs 2 cycles after reset release.
- io_retired updates on the clock edge that leaves WB.

## Configuration
- YSYX_25030077_SEQ_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to FETCH or MEM and increments on each cycle without valid.
  - If the counter reaches TIMEOUT with no valid arriving, the FSM goes to HALT with io_halt=1 and io_err=1.
  - A valid that arrives in the cycle the counter reaches TIMEOUT wins: the FSM proceeds normally.
- YSYX_25030077_SEQ_TIMEOUT_EN undefined:
  - No counter is built and waits are unbounded.
  - io_err is set only by an illegal instruction.

## Test plan
- Reset release with io_ifu_valid=1 tied, class 0 stream: io_ifu_req rises on cycle 2. io_data_control reads 0,0,0,0 across FETCH/DECODE/EXEC/WB. io_rf_wen=1 and io_pc_wen=1 in WB. io_retired=1 after 4 cycles and 10 after 40 cycles.
- LOAD (class 2) with io_lsu_valid delayed 3 cycles: io_lsu_req=1 for 4 cycles with io_lsu_wen=0. io_data_control=0 in EXEC and MEM, then 2 in WB, with io_rf_wen=1.
- STORE (class 3): io_lsu_wen=1 throughout MEM; WB has io_rf_wen=0 and io_pc_wen=1. Class 4 gives io_data_control=1 in EXEC; class 5 gives 3 with io_rf_wen=0.
- Class 6 gives io_halt=1, io_err=0, io_busy=0. Class 7 gives io_halt=1 and io_err=1. Further io_ifu_valid pulses leave all outputs unchanged until reset=0.
- Assert reset=0 mid-MEM while io_lsu_req=1: io_lsu_req=0 within the same cycle and io_retired=0. After release, the FSM restarts at IDLE.
- With YSYX_25030077_SEQ_TIMEOUT_EN and TIMEOUT=8, hold io_lsu_valid=0: io_halt=1 and io_err=1 after 8 MEM cycles. Without the macro, the FSM stays in MEM for 1000 cycles with io_err=0.
